// File: rtl/approx_mult_pkg.sv
// Shared encodings and helpers for the tiled approximate multiplier.
// Each tile mode selects how many low bits of its 8-bit partial product are dropped.
package approx_mult_pkg;

  localparam logic [1:0] MODE_EXACT = 2'b00;
  localparam logic [1:0] MODE_T2    = 2'b01;
  localparam logic [1:0] MODE_T3    = 2'b10;
  localparam logic [1:0] MODE_T4    = 2'b11;

  function automatic logic [7:0] mode_mask(input logic [1:0] mode);
    logic [7:0] m;
    m = 8'hFF;
    case (mode)
      MODE_EXACT: m = 8'hFF;
      MODE_T2:    m = 8'hFC;
      MODE_T3:    m = 8'hF8;
      MODE_T4:    m = 8'hF0;
      default:    m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/approx_tile_4x4.sv
// Combinational 4x4 partial-product tile.
// The exact product is masked according to the tile's approximation mode.
module approx_tile_4x4
  import approx_mult_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] mode,
  output logic [7:0] p
);

  logic [7:0] prod;

  always_comb begin
    prod = {4'b0000, a} * {4'b0000, b};
    p    = prod & mode_mask(mode);
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage pipelined approximate unsigned multiplier built from 4x4 tiles.
// It uses a global-stall valid/ready handshake and snapshots the tile modes at acceptance.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int         WIDTH        = 8,
  parameter int         TAG_W        = 4,
  parameter logic [1:0] DEFAULT_MODE = 2'b00,
  localparam int        NT           = WIDTH / 4,
  localparam int        TILES        = NT * NT,
  localparam int        MODE_W       = 2 * TILES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [MODE_W-1:0]    cfg_mode,
  output logic [MODE_W-1:0]    mode_q,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_r,
  output logic [TAG_W-1:0]     out_tag
);

  logic                stall;
  logic [MODE_W-1:0]   mode_d;

  logic                s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]    s1_a_q, s1_a_d;
  logic [WIDTH-1:0]    s1_b_q, s1_b_d;
  logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;
  logic [MODE_W-1:0]   s1_mode_q, s1_mode_d;

  logic [7:0]          tile_p [TILES];

  logic                s2_valid_q, s2_valid_d;
  logic [7:0]          s2_p_q [TILES];
  logic [7:0]          s2_p_d [TILES];
  logic [TAG_W-1:0]    s2_tag_q, s2_tag_d;

  logic [2*WIDTH-1:0]  sum_d;
  logic [2*WIDTH-1:0]  ext;

  logic                s3_valid_q, s3_valid_d;
  logic [2*WIDTH-1:0]  s3_r_q, s3_r_d;
  logic [TAG_W-1:0]    s3_tag_q, s3_tag_d;

  assign stall     = s3_valid_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = s3_valid_q;
  assign out_r     = s3_r_q;
  assign out_tag   = s3_tag_q;

  for (genvar t = 0; t < TILES; t++) begin : g_tile
    approx_tile_4x4 u_tile (
      .a    (s1_a_q[4*(t/NT) +: 4]),
      .b    (s1_b_q[4*(t%NT) +: 4]),
      .mode (s1_mode_q[2*t +: 2]),
      .p    (tile_p[t])
    );
  end

  // Exact adder tree: tile (i,j) carries weight 16^(i+j).
  always_comb begin
    sum_d = '0;
    ext   = '0;
    for (int unsigned i = 0; i < NT; i++) begin
      for (int unsigned j = 0; j < NT; j++) begin
        ext        = '0;
        ext[7:0]   = s2_p_q[i*NT + j];
        sum_d      = sum_d + (ext << (4 * (i + j)));
      end
    end
  end

  // A stall freezes every stage, bubbles included; cfg writes proceed regardless.
  always_comb begin
    mode_d     = cfg_we ? cfg_mode : mode_q;
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_p_d     = s2_p_q;
    s2_tag_d   = s2_tag_q;
    s3_valid_d = s3_valid_q;
    s3_r_d     = s3_r_q;
    s3_tag_d   = s3_tag_q;
    if (!stall) begin
      s1_valid_d = in_valid;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_tag_d   = in_tag;
      s1_mode_d  = mode_q;
      s2_valid_d = s1_valid_q;
      s2_p_d     = tile_p;
      s2_tag_d   = s1_tag_q;
      s3_valid_d = s2_valid_q;
      s3_r_d     = sum_d;
      s3_tag_d   = s2_tag_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= {TILES{DEFAULT_MODE}};
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      s1_mode_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_p_q     <= '{default: '0};
      s2_tag_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_r_q     <= '0;
      s3_tag_q   <= '0;
    end else begin
      mode_q     <= mode_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_p_q     <= s2_p_d;
      s2_tag_q   <= s2_tag_d;
      s3_valid_q <= s3_valid_d;
      s3_r_q     <= s3_r_d;
      s3_tag_q   <= s3_tag_d;
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed self-checking bench for approx_mult_pipe at WIDTH 8, 4 and 16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_approx_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // WIDTH=8 instance
  logic        cfg_we, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  cfg_mode, mode_q, in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] out_r;

  // WIDTH=4 instance
  logic        cfg_we_4, in_valid_4, in_ready_4, out_valid_4, out_ready_4;
  logic [1:0]  cfg_mode_4, mode_q_4, in_tag_4, out_tag_4;
  logic [3:0]  in_a_4, in_b_4;
  logic [7:0]  out_r_4;

  // WIDTH=16 instance
  logic        cfg_we_16, in_valid_16, in_ready_16, out_valid_16, out_ready_16;
  logic [31:0] cfg_mode_16, mode_q_16, out_r_16;
  logic [15:0] in_a_16, in_b_16;
  logic [3:0]  in_tag_16, out_tag_16;

  approx_mult_pipe #(.WIDTH(8), .TAG_W(4), .DEFAULT_MODE(2'b00)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .mode_q(mode_q),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag)
  );

  approx_mult_pipe #(.WIDTH(4), .TAG_W(2), .DEFAULT_MODE(2'b01)) u_dut4 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we_4), .cfg_mode(cfg_mode_4), .mode_q(mode_q_4),
    .in_valid(in_valid_4), .in_ready(in_ready_4), .in_a(in_a_4), .in_b(in_b_4),
    .in_tag(in_tag_4), .out_valid(out_valid_4), .out_ready(out_ready_4), .out_r(out_r_4),
    .out_tag(out_tag_4)
  );

  approx_mult_pipe #(.WIDTH(16), .TAG_W(4), .DEFAULT_MODE(2'b00)) u_dut16 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we_16), .cfg_mode(cfg_mode_16), .mode_q(mode_q_16),
    .in_valid(in_valid_16), .in_ready(in_ready_16), .in_a(in_a_16), .in_b(in_b_16),
    .in_tag(in_tag_16), .out_valid(out_valid_16), .out_ready(out_ready_16), .out_r(out_r_16),
    .out_tag(out_tag_16)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_mode(input logic [7:0] m);
    cfg_we   = 1'b1;
    cfg_mode = m;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg.mode_q", mode_q, m);
  endtask

  // One isolated beat with exact three-cycle latency check.
  task automatic send_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] t, input logic [15:0] exp_r);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    check({tag, ".in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".early1"}, out_valid, 0);
    @(negedge clk);
    check({tag, ".early2"}, out_valid, 0);
    @(negedge clk);
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".r"}, out_r, exp_r);
    check({tag, ".tag"}, out_tag, t);
  endtask

  task automatic expect_out(input string tag, input logic [15:0] exp_r, input logic [3:0] t);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, ".valid"}, seen, 1);
    check({tag, ".r"}, out_r, exp_r);
    check({tag, ".tag"}, out_tag, t);
  endtask

  logic [7:0]  va [8] = '{8'h3C, 8'hA7, 8'h01, 8'hFF, 8'h80, 8'h5D, 8'h00, 8'hE2};
  logic [7:0]  vb [8] = '{8'h91, 8'h2B, 8'hFE, 8'h10, 8'h80, 8'hC6, 8'h77, 8'hE2};
  logic [15:0] exp_q [$];
  logic [3:0]  tag_q [$];

  initial begin
    int sent;
    int got;
    bit seen;

    rst = 1'b1;
    cfg_we = 0; cfg_mode = '0; in_valid = 0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1;
    cfg_we_4 = 0; cfg_mode_4 = '0; in_valid_4 = 0; in_a_4 = '0; in_b_4 = '0; in_tag_4 = '0;
    out_ready_4 = 1;
    cfg_we_16 = 0; cfg_mode_16 = '0; in_valid_16 = 0; in_a_16 = '0; in_b_16 = '0;
    in_tag_16 = '0; out_ready_16 = 1;

    repeat (2) @(negedge clk);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_r", out_r, 0);
    check("rst.out_tag", out_tag, 0);
    check("rst.mode_q", mode_q, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("idle.in_ready", in_ready, 1);
    check("idle.out_valid", out_valid, 0);

    // Exact and per-tile approximation
    send_one("exact_ff", 8'hFF, 8'hFF, 4'h3, 16'd65025);
    send_one("exact_f0", 8'hF0, 8'hF0, 4'h5, 16'd57600);
    set_mode(8'h55);
    send_one("t2_ff", 8'hFF, 8'hFF, 4'h6, 16'd64736);
    set_mode(8'hC0);
    send_one("tile3_f0", 8'hF0, 8'hF0, 4'h7, 16'd57344);
    send_one("tile3_ff", 8'hFF, 8'hFF, 4'h2, 16'd64769);

    // cfg write in the same cycle as a beat: that beat keeps the old modes
    set_mode(8'h00);
    cfg_we = 1'b1; cfg_mode = 8'hFF;
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_tag = 4'h8;
    @(negedge clk);
    cfg_we = 1'b0;
    check("race.mode_q", mode_q, 8'hFF);
    in_a = 8'h11; in_b = 8'h11; in_tag = 4'h9;
    @(negedge clk);
    in_valid = 1'b0;
    expect_out("race.old", 16'd65025, 4'h8);
    expect_out("race.new", 16'd0, 4'h9);

    // Backpressure: back-to-back beats with out_ready low for cycles 5..8
    set_mode(8'h00);
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 8);
      if (sent < 8) begin
        in_valid = 1'b1;
        in_a     = va[sent];
        in_b     = vb[sent];
        in_tag   = 4'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("bp.in_ready", in_ready, !(cyc >= 5 && cyc <= 8));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("bp.extra", out_valid, 0);
        end else begin
          check("bp.r", out_r, exp_q[0]);
          check("bp.tag", out_tag, tag_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(tag_q.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(16'(va[sent]) * 16'(vb[sent]));
        tag_q.push_back(4'(sent));
        sent++;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp.count", got, 8);

    // Asynchronous reset with three beats in flight
    set_mode(8'h5A);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_a = 8'h21 + 8'(k); in_b = 8'h13; in_tag = 4'hA + 4'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("arst.pre_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("arst.out_valid", out_valid, 0);
    check("arst.out_r", out_r, 0);
    check("arst.out_tag", out_tag, 0);
    check("arst.mode_q", mode_q, 8'h00);
    check("arst.in_ready", in_ready, 1);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("arst.no_stale", seen, 0);

    // WIDTH=4: default mode 01 replicated
    check("w4.mode_q", mode_q_4, 2'b01);
    in_valid_4 = 1'b1; in_a_4 = 4'hF; in_b_4 = 4'hF; in_tag_4 = 2'd2;
    @(negedge clk);
    in_a_4 = 4'hD; in_b_4 = 4'hB; in_tag_4 = 2'd1;
    @(negedge clk);
    in_valid_4 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid_4) begin seen = 1'b1; break; end
    end
    check("w4.valid", seen, 1);
    check("w4.r0", out_r_4, 8'd224);
    check("w4.tag0", out_tag_4, 2'd2);
    @(negedge clk);
    check("w4.valid1", out_valid_4, 1);
    check("w4.r1", out_r_4, 8'd140);
    check("w4.tag1", out_tag_4, 2'd1);

    // WIDTH=16: exact, all-T4 and a single-tile mode, with config races
    check("w16.mode_q", mode_q_16, 32'h0);
    in_valid_16 = 1'b1; in_a_16 = 16'hFFFF; in_b_16 = 16'hFFFF; in_tag_16 = 4'd1;
    cfg_we_16 = 1'b1; cfg_mode_16 = 32'hFFFF_FFFF;
    @(negedge clk);
    in_tag_16 = 4'd2;
    cfg_mode_16 = 32'h0000_0002;
    @(negedge clk);
    cfg_we_16 = 1'b0;
    in_a_16 = 16'h0007; in_b_16 = 16'h0007; in_tag_16 = 4'd3;
    @(negedge clk);
    in_valid_16 = 1'b0;
    check("w16.valid0", out_valid_16, 1);
    check("w16.r0", out_r_16, 32'hFFFE_0001);
    check("w16.tag0", out_tag_16, 4'd1);
    @(negedge clk);
    check("w16.r1", out_r_16, 32'd4275748064);
    check("w16.tag1", out_tag_16, 4'd2);
    @(negedge clk);
    check("w16.r2", out_r_16, 32'd48);
    check("w16.tag2", out_tag_16, 4'd3);
    @(negedge clk);
    check("w16.drain", out_valid_16, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
